// File: rtl/ping_pong_ctrl.sv
// Ping-pong buffer control stage.
// Handshake semantics (both streams): a beat transfers on a rising clk edge
// where valid and ready are both high. The producer holds data stable until
// then, and valid does not depend on ready.
// Frames of BANK_DEPTH samples go into alternating RAM banks through port A.
// Each complete bank is streamed out of port B through a 2-entry output FIFO.
// The FIFO hides the one-cycle RAM read latency and keeps backpressure exact.
module ping_pong_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int BANK_DEPTH = 8,
   parameter int ADDRW      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   // input sample stream
   input  logic [DATA_WIDTH-1:0] s_tdata,
   input  logic                  s_tvalid,
   output logic                  s_tready,
   // dp_ram port A (write)
   output logic                  ram_ena,
   output logic                  ram_wea,
   output logic [ADDRW-1:0]      ram_addra,
   output logic [DATA_WIDTH-1:0] ram_dia,
   // dp_ram port B (read)
   output logic                  ram_enb,
   output logic [ADDRW-1:0]      ram_addrb,
   input  logic [DATA_WIDTH-1:0] ram_dob,
   // output sample stream
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic                  m_tlast,
   // bank status and read FSM state (debug visibility)
   output logic [1:0]            bank_full,
   output logic                  rd_state
);

   localparam int CNTW = ADDRW - 1;
   localparam logic [CNTW-1:0] LAST_CNT = CNTW'(BANK_DEPTH - 1);

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_READ = 1'b1
   } rd_state_t;

   rd_state_t             state_q, state_d;

   logic                  wr_bank;
   logic [CNTW-1:0]       wr_cnt;
   logic                  rd_bank;
   logic [CNTW-1:0]       rd_cnt;

   logic                  wr_hs;
   logic                  wr_last;
   logic                  rd_go;
   logic                  issue_ok;
   logic                  rd_last_issue;
   logic [1:0]            full_set;
   logic [1:0]            full_clr;

   logic                  rd_inflight;
   logic                  rd_inflight_last;

   logic [DATA_WIDTH-1:0] fifo_data [2];
   logic                  fifo_last [2];
   logic                  fifo_wptr;
   logic                  fifo_rptr;
   logic [1:0]            fifo_cnt;
   logic                  fifo_pop;
   logic [2:0]            occ_eff;

   assign rd_state = state_q;

   // Write side: accept whenever the current write bank is not holding an unread frame
   always_comb begin
      s_tready  = ~rst & ~bank_full[wr_bank];
      wr_hs     = s_tvalid & s_tready;
      wr_last   = wr_hs & (wr_cnt == LAST_CNT);
      ram_ena   = wr_hs;
      ram_wea   = wr_hs;
      ram_addra = {wr_bank, wr_cnt};
      ram_dia   = s_tdata;
   end

   // Read issue gating: occupancy counts the slot freed by a pop this cycle,
   // so a steadily draining stream issues one read per cycle without bubbles
   always_comb begin
      fifo_pop = m_tvalid & m_tready;
      occ_eff  = {1'b0, fifo_cnt} - {2'b00, fifo_pop} + {2'b00, rd_inflight};
      issue_ok = (occ_eff < 3'd2);
   end

   // Read FSM next state; IDLE issues the first read of a newly full bank at once
   always_comb begin
      state_d       = state_q;
      rd_go         = 1'b0;
      case (state_q)
         RD_IDLE: rd_go = bank_full[rd_bank];
         RD_READ: rd_go = 1'b1;
         default: rd_go = 1'b0;
      endcase
      ram_enb       = ~rst & rd_go & issue_ok;
      ram_addrb     = {rd_bank, rd_cnt};
      rd_last_issue = ram_enb & (rd_cnt == LAST_CNT);
      case (state_q)
         RD_IDLE: if (bank_full[rd_bank]) state_d = RD_READ;
         RD_READ: if (rd_last_issue) state_d = RD_IDLE;
         default: state_d = RD_IDLE;
      endcase
      if (rd_last_issue) state_d = RD_IDLE;
   end

   // Bank set/clear requests; a bank cannot be set and cleared in the same cycle
   always_comb begin
      full_set = 2'b00;
      full_clr = 2'b00;
      if (wr_last) full_set[wr_bank] = 1'b1;
      if (rd_last_issue) full_clr[rd_bank] = 1'b1;
   end

   // Write pointer: count within the bank, flip bank at frame end
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_cnt  <= '0;
         wr_bank <= 1'b0;
      end else if (wr_hs) begin
         if (wr_last) begin
            wr_cnt  <= '0;
            wr_bank <= ~wr_bank;
         end else begin
            wr_cnt <= wr_cnt + 1'b1;
         end
      end
   end

   // Read pointer and FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RD_IDLE;
         rd_cnt  <= '0;
         rd_bank <= 1'b0;
      end else begin
         state_q <= state_d;
         if (ram_enb) begin
            if (rd_last_issue) begin
               rd_cnt  <= '0;
               rd_bank <= ~rd_bank;
            end else begin
               rd_cnt <= rd_cnt + 1'b1;
            end
         end
      end
   end

   // Bank ownership flags; simultaneous set and clear of different banks both apply
   always_ff @(posedge clk) begin
      if (rst) begin
         bank_full <= 2'b00;
      end else begin
         bank_full <= (bank_full | full_set) & ~full_clr;
      end
   end

   // Track the read issued last cycle so its data is captured from ram_dob
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_inflight      <= 1'b0;
         rd_inflight_last <= 1'b0;
      end else begin
         rd_inflight      <= ram_enb;
         rd_inflight_last <= rd_last_issue;
      end
   end

   // Output FIFO storage; contents are don't-care while the FIFO is empty
   always_ff @(posedge clk) begin
      if (rd_inflight) begin
         fifo_data[fifo_wptr] <= ram_dob;
         fifo_last[fifo_wptr] <= rd_inflight_last;
      end
   end

   // Output FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         fifo_wptr <= 1'b0;
         fifo_rptr <= 1'b0;
         fifo_cnt  <= 2'd0;
      end else begin
         if (rd_inflight) fifo_wptr <= ~fifo_wptr;
         if (fifo_pop) fifo_rptr <= ~fifo_rptr;
         fifo_cnt <= fifo_cnt + {1'b0, rd_inflight} - {1'b0, fifo_pop};
      end
   end

   // Output stream is the FIFO head, held stable until it is accepted
   always_comb begin
      m_tvalid = (fifo_cnt != 2'd0);
      m_tdata  = fifo_data[fifo_rptr];
      m_tlast  = m_tvalid & fifo_last[fifo_rptr];
   end

endmodule

// File: tb/tb_ping_pong_ctrl.sv
// Bench for ping_pong_ctrl with a behavioural dp_ram model (one-cycle read latency).
// Accepted input samples are pushed to an expected queue and popped on output beats.
module tb_ping_pong_ctrl;

   localparam int DW = 32;
   localparam int BD = 8;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] s_tdata = '0;
   logic          s_tvalid = 1'b0;
   logic          s_tready;
   logic          ram_ena, ram_wea, ram_enb;
   logic [AW-1:0] ram_addra, ram_addrb;
   logic [DW-1:0] ram_dia, ram_dob;
   logic [DW-1:0] m_tdata;
   logic          m_tvalid;
   logic          m_tready = 1'b0;
   logic          m_tlast;
   logic [1:0]    bank_full;
   logic          rd_state;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [DW:0] exp_q[$];
   int          m_wr_cnt = 0;
   logic        m_wr_bank = 1'b0;
   logic        have_stall = 1'b0;
   logic [DW-1:0] stall_data;
   logic        stall_last;
   int          stall_checks = 0;
   int          out_n = 0;
   int          first_out = 0;
   int          last_out = 0;
   int          in_stalls = 0;

   ping_pong_ctrl #(.DATA_WIDTH(DW), .BANK_DEPTH(BD), .ADDRW(AW)) dut (
      .clk(clk), .rst(rst),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
      .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dia(ram_dia),
      .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_dob(ram_dob),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
      .bank_full(bank_full), .rd_state(rd_state)
   );

   // clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // dp_ram model
   logic [DW-1:0] ram_mem [0:2*BD-1];
   always @(posedge clk) begin
      if (ram_ena && ram_wea) ram_mem[ram_addra] <= ram_dia;
      if (ram_enb) ram_dob <= ram_mem[ram_addrb];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // scoreboard monitor, sampled mid-low-phase
   always @(negedge clk) begin
      logic [DW:0]   e;
      logic [AW-1:0] exp_a;
      #2;
      if (rst) begin
         exp_q.delete();
         m_wr_cnt   = 0;
         m_wr_bank  = 1'b0;
         have_stall = 1'b0;
      end else begin
         if (s_tvalid && s_tready) begin
            exp_a = {m_wr_bank, 3'(m_wr_cnt)};
            check("ram_we", {62'd0, ram_ena, ram_wea}, 64'd3);
            check("ram_addra", 64'(ram_addra), 64'(exp_a));
            check("ram_dia", 64'(ram_dia), 64'(s_tdata));
            exp_q.push_back({(m_wr_cnt == BD - 1), s_tdata});
            if (m_wr_cnt == BD - 1) begin
               m_wr_cnt  = 0;
               m_wr_bank = ~m_wr_bank;
            end else begin
               m_wr_cnt++;
            end
         end
         if (have_stall) begin
            stall_checks++;
            check("stall_valid", 64'(m_tvalid), 64'd1);
            check("stall_data", 64'(m_tdata), 64'(stall_data));
            check("stall_last", 64'(m_tlast), 64'(stall_last));
         end
         have_stall = m_tvalid && !m_tready;
         stall_data = m_tdata;
         stall_last = m_tlast;
         if (m_tvalid && m_tready) begin
            check("out_avail", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("out_data", 64'(m_tdata), 64'(e[DW-1:0]));
               check("out_last", 64'(m_tlast), 64'(e[DW]));
            end
            if (out_n == 0) first_out = cyc;
            last_out = cyc;
            out_n++;
         end
      end
   end

   // drive one sample; returns just after the accepting edge
   task automatic send(input logic [DW-1:0] d);
      logic ok;
      ok = 1'b0;
      s_tdata  = d;
      s_tvalid = 1'b1;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (s_tready) begin
            ok = 1'b1;
            break;
         end
         in_stalls++;
      end
      if (!ok) check("send_accept", 64'(ok), 64'd1);
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      check(tag, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      logic       found;
      logic [3:0] pat;
      pat = 4'b1001;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_s_tready", 64'(s_tready), 64'd0);
      check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
      check("rst_m_tlast", 64'(m_tlast), 64'd0);
      check("rst_bank_full", 64'(bank_full), 64'd0);
      check("rst_ram_en", {62'd0, ram_ena, ram_enb}, 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("s_tready_after_rst", 64'(s_tready), 64'd1);
      @(posedge clk);
      #1;

      // one frame at full rate, latency and back-to-back output
      m_tready = 1'b1;
      out_n = 0;
      for (int i = 0; i < BD; i++) send(DW'(32'h10 + i));
      @(negedge clk);
      check("lat_c1_valid", 64'(m_tvalid), 64'd0);
      check("lat_c1_enb", 64'(ram_enb), 64'd1);
      check("lat_c1_addrb", 64'(ram_addrb), 64'd0);
      @(negedge clk);
      check("lat_c2_valid", 64'(m_tvalid), 64'd0);
      @(negedge clk);
      check("lat_c3_valid", 64'(m_tvalid), 64'd1);
      check("lat_c3_data", 64'(m_tdata), 64'h10);
      drain("t1_drain");
      check("t1_count", 64'(out_n), 64'(BD));
      check("t1_contig", 64'(last_out - first_out), 64'(BD - 1));

      // 32 continuous samples
      out_n = 0;
      in_stalls = 0;
      for (int i = 0; i < 32; i++) send(DW'($urandom));
      drain("t2_drain");
      check("t2_in_stalls", 64'(in_stalls), 64'd0);
      check("t2_count", 64'(out_n), 64'd32);
      check("t2_contig", 64'(last_out - first_out), 64'd31);

      // both banks full under backpressure
      m_tready = 1'b0;
      out_n = 0;
      for (int i = 0; i < 2 * BD; i++) send(DW'($urandom));
      s_tdata  = DW'($urandom);
      s_tvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t3_full_s_tready", 64'(s_tready), 64'd0);
      end
      check("t3_bank_full", 64'(bank_full), 64'd3);
      @(posedge clk);
      #1 s_tvalid = 1'b0;
      m_tready = 1'b1;
      found = 1'b0;
      for (int t = 0; t < 60; t++) begin
         @(negedge clk);
         if (ram_enb && ram_addrb[AW-2:0] == 3'd7) begin
            found = 1'b1;
            break;
         end
      end
      check("t3_found_last_rd", 64'(found), 64'd1);
      check("t3_s_tready_before", 64'(s_tready), 64'd0);
      @(negedge clk);
      check("t3_s_tready_after", 64'(s_tready), 64'd1);
      drain("t3_drain");
      check("t3_count", 64'(out_n), 64'(2 * BD));

      // stalling output pattern 1,0,0,1
      m_tready = 1'b0;
      out_n = 0;
      stall_checks = 0;
      for (int i = 0; i < BD; i++) send(DW'($urandom));
      for (int i = 0; i < 48; i++) begin
         m_tready = pat[i % 4];
         @(posedge clk);
         #1;
      end
      m_tready = 1'b1;
      drain("t4_drain");
      check("t4_count", 64'(out_n), 64'(BD));
      check("t4_stalls_seen", 64'(stall_checks > 0), 64'd1);

      // reset in mid-frame
      for (int i = 0; i < 5; i++) send(DW'(32'h500 + i));
      pulse_reset();
      @(negedge clk);
      check("t5_bank_full", 64'(bank_full), 64'd0);
      check("t5_m_tvalid", 64'(m_tvalid), 64'd0);
      @(posedge clk);
      #1;
      out_n = 0;
      for (int i = 0; i < BD; i++) send(DW'(32'h5A0 + i));
      drain("t5_drain");
      check("t5_count", 64'(out_n), 64'(BD));

      // last write of bank 1 coincides with last read issue of bank 0
      pulse_reset();
      m_tready = 1'b0;
      out_n = 0;
      for (int i = 0; i < BD; i++) send(DW'(32'h600 + i));
      for (int i = 0; i < BD - 1; i++) send(DW'(32'h700 + i));
      @(negedge clk);
      check("t6_bank_full_pre", 64'(bank_full), 64'd1);
      @(posedge clk);
      #1 m_tready = 1'b1;
      found = 1'b0;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         if (ram_enb && ram_addrb == 4'd7) begin
            found = 1'b1;
            break;
         end
      end
      check("t6_found_last_rd", 64'(found), 64'd1);
      check("t6_bank_full_mid", 64'(bank_full), 64'd1);
      check("t6_s_tready", 64'(s_tready), 64'd1);
      s_tdata  = DW'(32'h700 + BD - 1);
      s_tvalid = 1'b1;
      @(posedge clk);
      #1 s_tvalid = 1'b0;
      @(negedge clk);
      check("t6_bank_full_post", 64'(bank_full), 64'd2);
      drain("t6_drain");
      check("t6_count", 64'(out_n), 64'(2 * BD));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ping_pong_ctrl.md
Name: ping_pong_ctrl

Overview:
Control stage in front of and behind dp_ram inside the ping-pong buffer IP. It accepts a streaming sample input, writes frames of BANK_DEPTH samples alternately into the two halves (banks) of dp_ram through port A, and streams each completed bank out through port B with valid/ready backpressure. It tracks bank ownership, hides the RAM's one-cycle read latency, and tags the last sample of each frame.

Parameters:
DATA_WIDTH, 32, sample width; equals dp_ram DATA_WIDTH
BANK_DEPTH, 8, samples per bank (frame); power of two, >=2
ADDRW, 4, RAM address width; must equal log2(2*BANK_DEPTH); MSB selects bank

Ports:
clk  in  1  single clock for all logic and the RAM
rst  in  1  synchronous reset, active-high
s_tdata  in  DATA_WIDTH  input sample
s_tvalid  in  1  input sample valid
s_tready  out  1  ctrl can accept a sample
ram_ena  out  1  to dp_ram ena
ram_wea  out  1  to dp_ram wea
ram_addra  out  ADDRW  to dp_ram addra
ram_dia  out  DATA_WIDTH  to dp_ram dia
ram_enb  out  1  to dp_ram enb
ram_addrb  out  ADDRW  to dp_ram addrb
ram_dob  in  DATA_WIDTH  from dp_ram dob; valid one cycle after ram_enb
m_tdata  out  DATA_WIDTH  output sample
m_tvalid  out  1  output sample valid
m_tready  in  1  downstream accepts
m_tlast  out  1  high on last sample of a bank
bank_full  out  2  bit i = bank i holds an unread frame

Behaviour:
- Clock is clk; reset is synchronous, active-high. In reset: wr_bank=rd_bank=0, wr_cnt=rd_cnt=0, bank_full=2'b00, output FIFO empty, m_tvalid=0, m_tlast=0, s_tready=0, ram_ena=ram_wea=ram_enb=0. s_tready=1 from the first cycle after rst deasserts.
- Write side: s_tready = ~rst & ~bank_full[wr_bank]. Input handshake (s_tvalid & s_tready) drives ram_ena=ram_wea=1, ram_addra={wr_bank, wr_cnt}, ram_dia=s_tdata combinationally in the same cycle; otherwise ram_ena=ram_wea=0.
- wr_cnt increments per handshake. On handshake with wr_cnt==BANK_DEPTH-1: wr_cnt<=0, bank_full[wr_bank]<=1, wr_bank toggles.
- Read side FSM: IDLE -> READ when bank_full[rd_bank]=1; READ -> IDLE after issuing address BANK_DEPTH-1.
- In READ, issue a read (ram_enb=1, ram_addrb={rd_bank, rd_cnt}) only when FIFO occupancy + reads in flight < 2. Otherwise ram_enb=0 and rd_cnt holds.
- Read data is captured from ram_dob into a 2-entry output FIFO on the cycle after issue, with a tlast flag set when rd_cnt was BANK_DEPTH-1. m_tdata, m_tvalid, and m_tlast come from the FIFO head, registered.
- Issuing read BANK_DEPTH-1 clears bank_full[rd_bank] (effective next cycle), toggles rd_bank, and sets rd_cnt<=0.
- Latency: last input handshake in cycle c -> first read issued c+1 -> m_tvalid=1 in c+3 (if FIFO was empty).
- With m_tready held high, output runs 1 sample/cycle continuously, with no bubbles inside a bank.
- m_tdata and m_tlast stay stable while m_tvalid=1 and m_tready=0.
- Both banks full: s_tready=0 until the reader releases one bank; no sample is ever dropped or overwritten.
- Simultaneous write-complete on one bank and read-release on the other in the same cycle: both bank_full updates apply.
- The freed bank is writable the cycle after release, which is safe because the last read was already issued.
- Address wrap: wr_cnt and rd_cnt wrap only at BANK_DEPTH-1, never across the bank MSB.
- Reset mid-frame discards partial and unread frames. The RAM contents are don't-care after reset.

Test Plan:
- Reset, then 8 samples 0x10..0x17 at full rate with m_tready=1 -> ram_addra 0..7; m_tvalid rises 3 cycles after the last beat; output 0x10..0x17 on consecutive cycles; m_tlast only on 0x17.
- Continuous 32 samples with m_tready=1 -> s_tready never drops after reset; output is an identical ordered stream; banks alternate (addra MSB toggles every 8 samples); m_tlast every 8th beat.
- m_tready=0, push 20 samples -> 16 accepted, bank_full=2'b11, s_tready=0 thereafter. Raise m_tready -> 16 samples out in order; s_tready returns 1 the cycle after the read of address 7 issues.
- m_tready toggling 1,0,0,1 pattern during a bank -> no loss or duplication; m_tdata is stable across each stall.
- Assert rst for 1 cycle after 5 samples of bank 0 -> bank_full=0, m_tvalid=0. The next 8 samples are written starting at address 0 and read out correctly.
- Last write to bank 1 in the same cycle as the last read issue of bank 0 -> bank_full goes 01 -> 10 with no glitch; both frames are delivered intact.
